// File: rtl/run_watchdog_if.sv
// Run watchdog bus: groups the per-channel halt/commit strobes, the error sources and
// the run-status outputs of run_watchdog.
//   master : drives halt, commit, err; observes the status outputs (testbench / SoC glue)
//   slave  : the watchdog itself
// Status outputs: done, done_code, halt_chan, err_latched, draining, cycle_count,
// commit_count.
interface run_watchdog_if #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned ERR_SRCS = 2
);
    logic [CHANNELS-1:0] halt;
    logic [CHANNELS-1:0] commit;
    logic [ERR_SRCS-1:0] err;

    logic                done;
    logic [2:0]          done_code;
    logic [3:0]          halt_chan;
    logic [ERR_SRCS-1:0] err_latched;
    logic                draining;
    logic [31:0]         cycle_count;
    logic [63:0]         commit_count;

    modport master (
        output halt, commit, err,
        input  done, done_code, halt_chan, err_latched, draining, cycle_count, commit_count
    );

    modport slave (
        input  halt, commit, err,
        output done, done_code, halt_chan, err_latched, draining, cycle_count, commit_count
    );
endinterface

// File: rtl/run_watchdog.sv
// Run watchdog: supervises a simulation/run and decides when and why it ends.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; release starts a fresh run
//   bus   : run_watchdog_if slave modport
//           in : halt[CHANNELS], commit[CHANNELS], err[ERR_SRCS]
//           out: done, done_code (0 run, 1 halt, 2 timeout, 3 error, 4 stall),
//                halt_chan, err_latched, draining, cycle_count, commit_count
// RUN ends on halt (immediate), error (through a DRAIN window), timeout or stall.
// DONE is absorbing until reset.
module run_watchdog #(
    parameter int unsigned CHANNELS     = 8,
    parameter int unsigned ERR_SRCS     = 2,
    parameter int unsigned TIMEOUT      = 10000000,
    parameter int unsigned STALL_LIMIT  = 0,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input logic           clk,
    input logic           rst_n,
    run_watchdog_if.slave bus
);

    localparam logic [2:0] CodeRun     = 3'd0;
    localparam logic [2:0] CodeHalt    = 3'd1;
    localparam logic [2:0] CodeTimeout = 3'd2;
    localparam logic [2:0] CodeError   = 3'd3;
    localparam logic [2:0] CodeStall   = 3'd4;

    localparam logic [31:0] TimeoutLoad = 32'(TIMEOUT);
    localparam logic [31:0] StallLimit  = 32'(STALL_LIMIT);
    localparam logic [7:0]  DrainLoad   = 8'(DRAIN_CYCLES - 1);
    localparam bit          StallEn     = (STALL_LIMIT != 0);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          code_q, code_d;
    logic [3:0]          chan_q, chan_d;
    logic [ERR_SRCS-1:0] errl_q, errl_d;
    logic [31:0]         tmo_q, tmo_d;
    logic [31:0]         stall_q, stall_d;
    logic [7:0]          drain_q, drain_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [63:0]         cmt_q, cmt_d;

    logic [4:0]          commit_pop;
    logic [3:0]          halt_idx;

    // Population count of this cycle's commit strobes.
    always_comb begin
        commit_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            commit_pop = commit_pop + 5'(bus.commit[i]);
        end
    end

    // Lowest-index halting channel: scan downwards so the lowest set bit wins.
    always_comb begin
        halt_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bus.halt[i]) begin
                halt_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        chan_d  = chan_q;
        errl_d  = errl_q;
        tmo_d   = tmo_q;
        stall_d = stall_q;
        drain_d = drain_q;
        cyc_d   = cyc_q;
        cmt_d   = cmt_q;

        // Counters advance in every non-DONE cycle, including the transition cycle.
        if (state_q != StDone) begin
            tmo_d   = (tmo_q == '0) ? '0 : tmo_q - 32'd1;
            cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
            cmt_d   = cmt_q + 64'(commit_pop);
            stall_d = (|bus.commit) ? '0 : ((&stall_q) ? stall_q : stall_q + 32'd1);
        end

        case (state_q)
            StRun: begin
                if (|bus.halt) begin
                    state_d = StDone;
                    code_d  = CodeHalt;
                    chan_d  = halt_idx;
                end else if (|bus.err) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                    errl_d  = bus.err;
                end else if (tmo_q == '0) begin
                    state_d = StDone;
                    code_d  = CodeTimeout;
                end else if (StallEn && (stall_q == StallLimit)) begin
                    state_d = StDone;
                    code_d  = CodeStall;
                end
            end
            StDrain: begin
                // Halt, timeout and stall are ignored here; errors keep accumulating.
                errl_d = errl_q | bus.err;
                if (drain_q == '0) begin
                    state_d = StDone;
                    code_d  = CodeError;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            code_q  <= CodeRun;
            chan_q  <= '0;
            errl_q  <= '0;
            tmo_q   <= TimeoutLoad;
            stall_q <= '0;
            drain_q <= '0;
            cyc_q   <= '0;
            cmt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            chan_q  <= chan_d;
            errl_q  <= errl_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
            drain_q <= drain_d;
            cyc_q   <= cyc_d;
            cmt_q   <= cmt_d;
        end
    end

    assign bus.done         = (state_q == StDone);
    assign bus.done_code    = code_q;
    assign bus.halt_chan    = chan_q;
    assign bus.err_latched  = errl_q;
    assign bus.draining     = (state_q == StDrain);
    assign bus.cycle_count  = cyc_q;
    assign bus.commit_count = cmt_q;

endmodule

// File: tb/tb_run_watchdog.sv
// Scoreboard bench for run_watchdog. Two instances share the clock:
//   dut_a : TIMEOUT=20, stall check disabled, DRAIN_CYCLES=5
//   dut_b : TIMEOUT=20, STALL_LIMIT=4,        DRAIN_CYCLES=5
// Stimulus pushes the expected end-of-run record; a monitor per instance pops and
// compares it on the first cycle done is seen.
module tb_run_watchdog;

    typedef struct {
        logic [2:0]  code;
        logic [3:0]  chan;
        logic [1:0]  errl;
        int unsigned cyc;
        longint unsigned cmt;
        int unsigned edge_n;
        int unsigned drn;
    } exp_t;

    logic clk;
    logic rst_na;
    logic rst_nb;

    run_watchdog_if #(.CHANNELS(8), .ERR_SRCS(2)) bus_a ();
    run_watchdog_if #(.CHANNELS(8), .ERR_SRCS(2)) bus_b ();

    run_watchdog #(
        .CHANNELS(8), .ERR_SRCS(2), .TIMEOUT(20), .STALL_LIMIT(0), .DRAIN_CYCLES(5)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (bus_a.slave)
    );

    run_watchdog #(
        .CHANNELS(8), .ERR_SRCS(2), .TIMEOUT(20), .STALL_LIMIT(4), .DRAIN_CYCLES(5)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bus_b.slave)
    );

    exp_t qa[$];
    exp_t qb[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned edge_a = 0;
    int unsigned edge_b = 0;
    int unsigned drn_a  = 0;
    int unsigned drn_b  = 0;
    bit          seen_a = 0;
    bit          seen_b = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Rising edges since reset release (edge 1 = first RUN cycle).
    always @(posedge clk or negedge rst_na) begin
        if (!rst_na) edge_a <= 0;
        else         edge_a <= edge_a + 1;
    end

    always @(posedge clk or negedge rst_nb) begin
        if (!rst_nb) edge_b <= 0;
        else         edge_b <= edge_b + 1;
    end

    task automatic cmp_end(input string tag, input exp_t e, input logic [2:0] code,
                           input logic [3:0] chan, input logic [1:0] errl,
                           input logic [31:0] cyc, input logic [63:0] cmt,
                           input int unsigned edge_n, input int unsigned drn);
        chk({tag, " done_code"},    64'(code),   64'(e.code));
        chk({tag, " halt_chan"},    64'(chan),   64'(e.chan));
        chk({tag, " err_latched"},  64'(errl),   64'(e.errl));
        chk({tag, " cycle_count"},  64'(cyc),    64'(e.cyc));
        chk({tag, " commit_count"}, cmt,         e.cmt);
        chk({tag, " done edge"},    64'(edge_n), 64'(e.edge_n));
        chk({tag, " drain cycles"}, 64'(drn),    64'(e.drn));
    endtask

    // Monitors: sample on the falling edge.
    always @(negedge clk) begin
        if (!rst_na) begin
            seen_a = 0;
            drn_a  = 0;
        end else if (!seen_a) begin
            if (bus_a.draining) drn_a++;
            if (bus_a.done) begin
                seen_a = 1;
                if (qa.size() == 0) begin
                    chk("dut_a unexpected done", 64'(bus_a.done_code), 64'd0);
                end else begin
                    cmp_end("dut_a", qa.pop_front(), bus_a.done_code, bus_a.halt_chan,
                            bus_a.err_latched, bus_a.cycle_count, bus_a.commit_count,
                            edge_a, drn_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_nb) begin
            seen_b = 0;
            drn_b  = 0;
        end else if (!seen_b) begin
            if (bus_b.draining) drn_b++;
            if (bus_b.done) begin
                seen_b = 1;
                if (qb.size() == 0) begin
                    chk("dut_b unexpected done", 64'(bus_b.done_code), 64'd0);
                end else begin
                    cmp_end("dut_b", qb.pop_front(), bus_b.done_code, bus_b.halt_chan,
                            bus_b.err_latched, bus_b.cycle_count, bus_b.commit_count,
                            edge_b, drn_b);
                end
            end
        end
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, " done"},         64'(bus_a.done),        64'd0);
        chk({tag, " done_code"},    64'(bus_a.done_code),   64'd0);
        chk({tag, " halt_chan"},    64'(bus_a.halt_chan),   64'd0);
        chk({tag, " err_latched"},  64'(bus_a.err_latched), 64'd0);
        chk({tag, " draining"},     64'(bus_a.draining),    64'd0);
        chk({tag, " cycle_count"},  64'(bus_a.cycle_count), 64'd0);
        chk({tag, " commit_count"}, bus_a.commit_count,     64'd0);
    endtask

    task automatic reset_a();
        rst_na = 1'b0;
        bus_a.halt = '0; bus_a.commit = '0; bus_a.err = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("reset_a");
        @(negedge clk);
        rst_na = 1'b1;
    endtask

    task automatic reset_b();
        rst_nb = 1'b0;
        bus_b.halt = '0; bus_b.commit = '0; bus_b.err = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_b done", 64'(bus_b.done), 64'd0);
        @(negedge clk);
        rst_nb = 1'b1;
    endtask

    // Hold the given inputs for n rising edges, returning 1 time unit after the last.
    task automatic drive_a(input logic [7:0] h, input logic [7:0] c, input logic [1:0] e,
                           input int n);
        bus_a.halt = h; bus_a.commit = c; bus_a.err = e;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_b(input logic [7:0] c, input int n);
        bus_b.halt = '0; bus_b.commit = c; bus_b.err = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 40 && !seen_a; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, " done seen within budget"}, 64'(seen_a), 64'd1);
        if (!seen_a) qa.delete();
    endtask

    task automatic wait_done_b(input string tag);
        for (int i = 0; i < 40 && !seen_b; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, " done seen within budget"}, 64'(seen_b), 64'd1);
        if (!seen_b) qb.delete();
    endtask

    initial begin
        rst_na = 1'b0;
        rst_nb = 1'b0;
        bus_a.halt = '0; bus_a.commit = '0; bus_a.err = '0;
        bus_b.halt = '0; bus_b.commit = '0; bus_b.err = '0;

        // Idle run reaches timeout after TIMEOUT+1 cycles.
        reset_a();
        qa.push_back('{code: 3'd2, chan: 4'd0, errl: 2'b00, cyc: 21, cmt: 0, edge_n: 21, drn: 0});
        wait_done_a("timeout");
        // DONE freezes everything regardless of inputs.
        drive_a(8'hFF, 8'hFF, 2'b11, 3);
        chk("frozen timeout code", 64'(bus_a.done_code), 64'd2);
        chk("frozen timeout cycles", 64'(bus_a.cycle_count), 64'd21);
        chk("frozen timeout commits", bus_a.commit_count, 64'd0);
        chk("frozen timeout err_latched", 64'(bus_a.err_latched), 64'd0);

        // Halt and err in the same cycle: halt wins, lowest channel reported.
        reset_a();
        drive_a(8'h00, 8'h00, 2'b00, 2);
        qa.push_back('{code: 3'd1, chan: 4'd3, errl: 2'b00, cyc: 3, cmt: 0, edge_n: 3, drn: 0});
        drive_a(8'h28, 8'h00, 2'b01, 1);
        wait_done_a("halt+err");

        // Halt on top channel; commits in the transition cycle are counted.
        reset_a();
        drive_a(8'h00, 8'h81, 2'b00, 3);
        qa.push_back('{code: 3'd1, chan: 4'd7, errl: 2'b00, cyc: 4, cmt: 8, edge_n: 4, drn: 0});
        drive_a(8'h80, 8'h81, 2'b00, 1);
        wait_done_a("halt ch7");

        // Error -> DRAIN for 5 cycles, later error OR-ed in, halt ignored while draining.
        reset_a();
        qa.push_back('{code: 3'd3, chan: 4'd0, errl: 2'b11, cyc: 7, cmt: 16, edge_n: 7, drn: 5});
        drive_a(8'h00, 8'h0F, 2'b00, 1);
        drive_a(8'h00, 8'h0F, 2'b01, 1);
        drive_a(8'h01, 8'h0F, 2'b00, 1);
        drive_a(8'h01, 8'h0F, 2'b10, 1);
        drive_a(8'h01, 8'h00, 2'b00, 3);
        drive_a(8'h00, 8'h00, 2'b00, 0);
        wait_done_a("drain");
        drive_a(8'hFF, 8'hFF, 2'b11, 3);
        chk("frozen drain cycles", 64'(bus_a.cycle_count), 64'd7);
        chk("frozen drain commits", bus_a.commit_count, 64'd16);
        chk("frozen drain draining", 64'(bus_a.draining), 64'd0);

        // Error in the very cycle the timeout would fire: error has priority.
        reset_a();
        drive_a(8'h00, 8'h00, 2'b00, 20);
        qa.push_back('{code: 3'd3, chan: 4'd0, errl: 2'b10, cyc: 26, cmt: 0, edge_n: 26, drn: 5});
        drive_a(8'h00, 8'h00, 2'b10, 1);
        drive_a(8'h00, 8'h00, 2'b00, 0);
        wait_done_a("err at timeout");

        // Reset two cycles into DRAIN clears everything asynchronously.
        reset_a();
        drive_a(8'h00, 8'h00, 2'b00, 1);
        drive_a(8'h00, 8'h03, 2'b01, 1);
        drive_a(8'h00, 8'h03, 2'b00, 2);
        chk("mid-drain draining before reset", 64'(bus_a.draining), 64'd1);
        rst_na = 1'b0;
        #1;
        chk_reset_a("async reset");
        reset_a();
        qa.push_back('{code: 3'd2, chan: 4'd0, errl: 2'b00, cyc: 21, cmt: 0, edge_n: 21, drn: 0});
        wait_done_a("timeout after reset");

        // Stall: three full-commit cycles then silence.
        reset_b();
        qb.push_back('{code: 3'd4, chan: 4'd0, errl: 2'b00, cyc: 8, cmt: 24, edge_n: 8, drn: 0});
        drive_b(8'hFF, 3);
        drive_b(8'h00, 0);
        wait_done_b("stall");

        // A commit mid-way restarts the stall window.
        reset_b();
        qb.push_back('{code: 3'd4, chan: 4'd0, errl: 2'b00, cyc: 10, cmt: 16, edge_n: 10, drn: 0});
        drive_b(8'hFF, 1);
        drive_b(8'h00, 3);
        drive_b(8'hFF, 1);
        drive_b(8'h00, 0);
        wait_done_b("stall restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
